// File: rtl/wb_arbiter.sv
// Writeback arbiter: three one-entry result buffers (ALU, LSU, MD) merged onto the single
// register file write port, fixed priority with age promotion; 2-cycle capture-to-write latency.
module wb_arbiter #(
  parameter int DataWidth    = 32,
  parameter int AddrRegWidth = 5,
  parameter int MaxWait      = 4
) (
  input  logic                       brq_clk,
  input  logic                       brq_rst,
  input  logic                       alu_valid,
  input  logic [AddrRegWidth-1:0]    alu_rd,
  input  logic [DataWidth-1:0]       alu_data,
  output logic                       alu_ready,
  input  logic                       lsu_valid,
  input  logic [AddrRegWidth-1:0]    lsu_rd,
  input  logic [DataWidth-1:0]       lsu_data,
  output logic                       lsu_ready,
  input  logic                       md_valid,
  input  logic [AddrRegWidth-1:0]    md_rd,
  input  logic [DataWidth-1:0]       md_data,
  output logic                       md_ready,
  output logic                       writeEn,
  output logic [AddrRegWidth-1:0]    writeDataSel,
  output logic [DataWidth-1:0]       writeData,
  output logic [2**AddrRegWidth-1:0] wb_pending
);

  localparam int NSrc = 3;
  localparam int NReg = 2**AddrRegWidth;

  logic [NSrc-1:0]         in_vld;
  logic [AddrRegWidth-1:0] in_rd   [NSrc];
  logic [DataWidth-1:0]    in_data [NSrc];

  logic [NSrc-1:0]         buf_v_q, buf_v_d;
  logic [AddrRegWidth-1:0] buf_rd_q   [NSrc];
  logic [AddrRegWidth-1:0] buf_rd_d   [NSrc];
  logic [DataWidth-1:0]    buf_data_q [NSrc];
  logic [DataWidth-1:0]    buf_data_d [NSrc];
  logic [3:0]              buf_age_q  [NSrc];
  logic [3:0]              buf_age_d  [NSrc];

  logic                    we_q, we_d;
  logic [AddrRegWidth-1:0] sel_q, sel_d;
  logic [DataWidth-1:0]    wdata_q, wdata_d;

  logic [NSrc-1:0]         promoted;
  logic [NSrc-1:0]         grant;
  logic [NSrc-1:0]         rdy;
  logic                    found;
  logic [AddrRegWidth-1:0] gnt_rd;
  logic [DataWidth-1:0]    gnt_data;

  assign in_vld     = {md_valid, lsu_valid, alu_valid};
  assign in_rd[0]   = alu_rd;
  assign in_rd[1]   = lsu_rd;
  assign in_rd[2]   = md_rd;
  assign in_data[0] = alu_data;
  assign in_data[1] = lsu_data;
  assign in_data[2] = md_data;

  // Grant looks only at buffer state, so ready never depends on the valid inputs.
  always_comb begin
    promoted = '0;
    grant    = '0;
    found    = 1'b0;
    gnt_rd   = '0;
    gnt_data = '0;
    for (int i = 0; i < NSrc; i++) begin
      promoted[i] = buf_v_q[i] && (buf_age_q[i] >= 4'(MaxWait));
    end
    for (int i = 0; i < NSrc; i++) begin
      if (!found && ((|promoted) ? promoted[i] : buf_v_q[i])) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < NSrc; i++) begin
      if (grant[i]) begin
        gnt_rd   = buf_rd_q[i];
        gnt_data = buf_data_q[i];
      end
    end
  end

  assign rdy       = ~buf_v_q | grant;
  assign alu_ready = rdy[0];
  assign lsu_ready = rdy[1];
  assign md_ready  = rdy[2];

  always_comb begin
    for (int i = 0; i < NSrc; i++) begin
      buf_v_d[i]    = buf_v_q[i];
      buf_rd_d[i]   = buf_rd_q[i];
      buf_data_d[i] = buf_data_q[i];
      buf_age_d[i]  = buf_age_q[i];
      if (in_vld[i] && rdy[i]) begin
        buf_v_d[i]    = 1'b1;
        buf_rd_d[i]   = in_rd[i];
        buf_data_d[i] = in_data[i];
        buf_age_d[i]  = '0;
      end else if (grant[i]) begin
        buf_v_d[i]   = 1'b0;
        buf_age_d[i] = '0;
      end else if (buf_v_q[i] && (buf_age_q[i] != 4'hF)) begin
        buf_age_d[i] = buf_age_q[i] + 4'd1;
      end
    end
    // Writes to x0 are consumed here but never reach the register file.
    we_d    = found && (gnt_rd != '0);
    sel_d   = found ? gnt_rd : sel_q;
    wdata_d = found ? gnt_data : wdata_q;
  end

  always_ff @(posedge brq_clk or posedge brq_rst) begin
    if (brq_rst) begin
      buf_v_q <= '0;
      for (int i = 0; i < NSrc; i++) begin
        buf_rd_q[i]   <= '0;
        buf_data_q[i] <= '0;
        buf_age_q[i]  <= '0;
      end
      we_q    <= 1'b0;
      sel_q   <= '0;
      wdata_q <= '0;
    end else begin
      buf_v_q <= buf_v_d;
      for (int i = 0; i < NSrc; i++) begin
        buf_rd_q[i]   <= buf_rd_d[i];
        buf_data_q[i] <= buf_data_d[i];
        buf_age_q[i]  <= buf_age_d[i];
      end
      we_q    <= we_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    wb_pending = '0;
    for (int i = 0; i < NSrc; i++) begin
      if (buf_v_q[i]) wb_pending[buf_rd_q[i]] = 1'b1;
    end
    if (we_q) wb_pending[sel_q] = 1'b1;
    wb_pending[0] = 1'b0;
  end

  assign writeEn      = we_q;
  assign writeDataSel = sel_q;
  assign writeData    = wdata_q;

  logic unused_nreg;
  assign unused_nreg = (NReg == 0);

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage directly upstream of the register file; it alone drives the register file write port (writeEn, writeDataSel, writeData).
- Collects results from three producers: single-cycle ALU, load/store unit (LSU) and multi-cycle mul/div unit (MD).
- Each producer has a one-entry holding buffer with a valid/ready handshake. Buffers are arbitrated to one write per cycle, with aging to prevent starvation.
- Exports a pending-destination mask for decode hazard stalls.

Parameters:
- DataWidth, 32, width of result data.
- AddrRegWidth, 5, register index width.
- MaxWait, 4, cycles a buffered entry may lose arbitration before it is promoted. Legal range 1..15.

Ports:
- brq_clk  input  1  clock. All state updates on its rising edge.
- brq_rst  input  1  asynchronous active-high reset.
- alu_valid  input  1  ALU result offered.
- alu_rd  input  AddrRegWidth  ALU destination register.
- alu_data  input  DataWidth  ALU result.
- alu_ready  output  1  ALU offer accepted this cycle.
- lsu_valid, lsu_rd, lsu_data, lsu_ready  same as ALU group, for load results.
- md_valid, md_rd, md_data, md_ready  same as ALU group, for mul/div results.
- writeEn  output  1  register file write enable (registered).
- writeDataSel  output  AddrRegWidth  register file write index (registered).
- writeData  output  DataWidth  register file write data (registered).
- wb_pending  output  2**AddrRegWidth  bit r set while a write to xr is in flight in this block.

Behaviour:
- Reset (asynchronous, while brq_rst=1): all buffers invalid; all ages 0; writeEn=0, writeDataSel=0, writeData=0; wb_pending=0. All ready outputs are 1 while brq_rst=1, but nothing is captured. Reset mid-operation discards every buffered result.
- Per-source buffer state: buf_v, buf_rd, buf_data, buf_age (4 bits).
- Handshake:
  - src_ready = !buf_v | grant_src (combinational).
  - Grant depends only on buffer state, never on *_valid inputs, so there is no combinational loop.
  - Transfer occurs when src_valid & src_ready at the rising edge: buffer loads rd/data, buf_v=1, buf_age=0.
  - A simultaneous grant and new transfer replaces the entry in the same edge, giving one result per cycle per source.
  - Producers must hold valid/rd/data stable until ready.
- Arbitration (combinational, at most one grant per cycle):
  - Promoted entries are those with buf_v & buf_age>=MaxWait.
  - If any entry is promoted, grant the first promoted entry in order ALU, LSU, MD.
  - Otherwise grant the first valid entry in fixed order ALU, LSU, MD.
  - Every valid, ungranted entry increments buf_age, saturating at 15.
- Output register (updated on a granted cycle):
  - writeEn <= (granted rd != 0).
  - writeDataSel <= granted rd.
  - writeData <= granted data.
  - With no grant: writeEn <= 0; writeDataSel and writeData hold their previous values.
  - Results for x0 are consumed and dropped: writeEn stays 0.
- Latency:
  - Transfer at edge E (end of cycle N).
  - Uncontested entry is granted in cycle N+1.
  - writeEn=1 is visible in cycle N+2; the register file commits at the end of N+2.
- wb_pending:
  - OR of one-hot(buf_rd) over valid buffers, plus one-hot(writeDataSel) when writeEn=1.
  - Bit 0 is forced to 0.
  - Derived combinationally from registers only.
- Same-rd ordering:
  - Across sources, grant order defines final register content.
  - The issue logic guarantees, using wb_pending, that two in-flight writes to the same rd never coexist.
  - The arbiter performs no rd comparison.
- Starvation bound: a valid entry is granted within MaxWait+2 cycles of capture under any input pattern.

Test Plan:
- Reset then idle: brq_rst pulse mid-cycle (asynchronous) -> writeEn=0, writeDataSel=0, writeData=0, wb_pending=0 immediately, with no clock edge needed. A buffered LSU entry present before reset is never written.
- Single ALU write: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for one cycle N -> alu_ready=1 in N; writeEn=1, writeDataSel=5, writeData=0xDEADBEEF in N+2 only; wb_pending[5]=1 in N+1..N+2, 0 in N+3.
- Simultaneous three-source: ALU rd=1, LSU rd=2, MD rd=3 all offered in cycle N with distinct data -> writes appear in N+2, N+3, N+4 in order 1, 2, 3; lsu_ready=0 and md_ready=0 while their buffers are occupied.
- Aging: MD rd=7 buffered; ALU and LSU both offer continuously with new rd every cycle -> MD wins no later than MaxWait+2=6 cycles after capture; ALU stalls (alu_ready=0) in that grant cycle.
- x0 drop: LSU rd=0, data=0x12345678 -> lsu_ready=1, buffer drains, writeEn stays 0, wb_pending stays 0.
- Back-to-back same source: ALU offers rd=10..13 in consecutive cycles with no contention -> alu_ready=1 every cycle; four consecutive writeEn=1 cycles with writeDataSel 10, 11, 12, 13.
